// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl: bit-serial adder driven by a small IDLE/RUN/DONE FSM.
// One full_adder is reused for every bit, LSB first, one bit per clock.
//
// Optional feature: define SERIAL_ADDER_SUB_EN to add the 'sub' input, which
// turns the operation into a - b (two's complement: ~b plus carry-in of 1).
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-high reset
//   start  in   request one operation (accepted in IDLE or DONE)
//   a, b   in   WIDTH-bit operands, sampled when start is accepted
//   c_in   in   carry-in, sampled when start is accepted
//   sub    in   (SERIAL_ADDER_SUB_EN only) subtract instead of add
//   busy   out  high while bits are being processed (RUN)
//   done   out  one-cycle completion pulse (DONE)
//   sum    out  registered result, updated only on entry to DONE
//   c_out  out  registered final carry (for subtract: 1 = no borrow)
// -----------------------------------------------------------------------------

module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    // One extra bit so the counter can reach WIDTH without wrapping.
    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  psum_q, psum_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;

    logic              fa_s, fa_c;
    logic [WIDTH-1:0]  b_load;
    logic              carry_load;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction as a + ~b + 1; c_in is ignored in that mode.
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : c_in;
`else
    assign b_load     = b;
    assign carry_load = c_in;
`endif

    full_adder u_fa (
        .a_i (a_q[0]),
        .b_i (b_q[0]),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_c)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        psum_d  = psum_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b_load;
                    carry_d = carry_load;
                    cnt_d   = '0;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                // Sum bits enter from the MSB side so bit 0 ends up at the bottom.
                psum_d  = {fa_s, psum_q[WIDTH-1:1]};
                carry_d = fa_c;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    sum_d   = {fa_s, psum_q[WIDTH-1:1]};
                    cout_d  = fa_c;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            psum_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            psum_q  <= psum_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign busy  = (state_q == StRun);
    assign done  = (state_q == StDone);
    assign sum   = sum_q;
    assign c_out = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for serial_adder_ctrl (WIDTH = 8): vector table, hand-written
// multi-cycle sequences, and random operations against an arithmetic model.
// -----------------------------------------------------------------------------

module tb_serial_adder_ctrl;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;

    int checks;
    int failures;

    logic [W-1:0] prev_sum;
    logic         prev_cout;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Full operation: start pulse, track busy/done timing, compare result.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tcin,
                          input logic [W-1:0] esum, input logic ecout);
        @(negedge clk);
        a     = ta;
        b     = tb_v;
        c_in  = tcin;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        for (int i = 1; i < int'(W); i++) begin
            @(posedge clk);
            #1;
            chk("busy_run", 32'(busy), 32'd1);
            chk("done_during_run", 32'(done), 32'd0);
            chk("sum_held", 32'(sum), 32'(prev_sum));
            chk("cout_held", 32'(c_out), 32'(prev_cout));
        end
        @(posedge clk);
        #1;
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_in_done", 32'(busy), 32'd0);
        chk("sum", 32'(sum), 32'(esum));
        chk("c_out", 32'(c_out), 32'(ecout));
        prev_sum  = esum;
        prev_cout = ecout;
        @(posedge clk);
        #1;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_not_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rc;
        logic [W:0]   full;

        checks    = 0;
        failures  = 0;
        prev_sum  = '0;
        prev_cout = 1'b0;

        vecs[0] = '{8'h3C, 8'h15, 1'b0, 8'h51, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[6] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
        vecs[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};

        // Reset state, checked before any clock edge.
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        c_in  = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub   = 1'b0;
`endif
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(c_out), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Table vectors.
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_sum, vecs[i].exp_cout);
        end

        // Start while RUN is ignored; no second done pulse.
        @(negedge clk);
        a = 8'h01; b = 8'h01; c_in = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        a = 8'hAA; b = 8'h55; c_in = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("ignored_start_busy", 32'(busy), 32'd1);
        for (int i = 4; i < 8; i++) begin
            @(posedge clk);
            #1;
            chk("ignored_start_run", 32'(busy), 32'd1);
        end
        @(posedge clk);
        #1;
        chk("ignored_start_done", 32'(done), 32'd1);
        chk("ignored_start_sum", 32'(sum), 32'h02);
        chk("ignored_start_cout", 32'(c_out), 32'd0);
        prev_sum = 8'h02; prev_cout = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            chk("no_extra_done", 32'(done), 32'd0);
        end

        // Reset mid-run: outputs clear at once, no done afterwards.
        @(negedge clk);
        a = 8'h3C; b = 8'h15; c_in = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_cout", 32'(c_out), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("start_in_rst_busy", 32'(busy), 32'd0);
        end
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        prev_sum = '0; prev_cout = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            chk("no_done_after_rst", 32'(done), 32'd0);
            chk("idle_after_rst", 32'(busy), 32'd0);
        end
        run_op(8'h12, 8'h34, 1'b1, 8'h47, 1'b0);

        // Back-to-back: start held through DONE.
        @(negedge clk);
        a = 8'h3C; b = 8'h15; c_in = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        a = 8'hF0; b = 8'h20; c_in = 1'b1;
        for (int i = 1; i < 8; i++) begin
            @(posedge clk);
            #1;
            chk("b2b_run1", 32'(busy), 32'd1);
            chk("b2b_hold1", 32'(sum), 32'(prev_sum));
        end
        @(posedge clk);
        #1;
        chk("b2b_done1", 32'(done), 32'd1);
        chk("b2b_sum1", 32'(sum), 32'h51);
        chk("b2b_cout1", 32'(c_out), 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_restart_busy", 32'(busy), 32'd1);
        chk("b2b_restart_done", 32'(done), 32'd0);
        chk("b2b_hold2", 32'(sum), 32'h51);
        for (int i = 1; i < 8; i++) begin
            @(posedge clk);
            #1;
            chk("b2b_run2", 32'(busy), 32'd1);
            chk("b2b_nodone2", 32'(done), 32'd0);
        end
        @(posedge clk);
        #1;
        chk("b2b_done2", 32'(done), 32'd1);
        chk("b2b_sum2", 32'(sum), 32'h11);
        chk("b2b_cout2", 32'(c_out), 32'd1);
        prev_sum = 8'h11; prev_cout = 1'b1;
        @(posedge clk);
        #1;
        chk("b2b_end", 32'(done), 32'd0);

        // Random operations against plain arithmetic.
        for (int n = 0; n < 20; n++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            rc   = 1'($urandom_range(0, 1));
            full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run_op(ra, rb, rc, full[W-1:0], full[W]);
        end

`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b1;
        run_op(8'h05, 8'h07, 1'b0, 8'hFE, 1'b0);
        run_op(8'h07, 8'h05, 1'b1, 8'h02, 1'b1);
        for (int n = 0; n < 10; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom_range(0, 1));
            run_op(ra, rb, rc, W'(ra - rb), (ra >= rb));
        end
        sub = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving operand width in bits; legal range 2..32.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port start, input, 1, request to begin one addition.
REQ-005 SHALL have ports a and b, input, WIDTH each, operands sampled on start acceptance.
REQ-006 SHALL have port c_in, input, 1, carry-in sampled on start acceptance.
REQ-007 SHALL have port busy, output, 1, high while bits are being processed.
REQ-008 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-009 SHALL have port sum, output, WIDTH, registered result.
REQ-010 SHALL have port c_out, output, 1, registered final carry.

Function
REQ-011 SHALL instantiate exactly one full_adder and compute all WIDTH bits through it, one bit per cycle, LSB first.
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 IDLE: start high at edge E -> load a, b into operand shift registers, carry flop <= c_in, bit counter <= 0, state <= RUN.
REQ-014 RUN: each edge feeds operand LSBs and carry flop to the full adder, shifts operands right, shifts adder sum into the partial-sum register from the MSB side, carry flop <= adder c_out, counter +1.
REQ-015 RUN: the edge that processes bit WIDTH-1 (edge E+WIDTH) SHALL copy partial sum to sum, final carry to c_out, and move state to DONE.
REQ-016 DONE: done high for exactly one cycle (between edges E+WIDTH and E+WIDTH+1); the next edge returns to IDLE, or to RUN if start is high (back-to-back, same loading as REQ-013).
REQ-017 busy SHALL be high exactly when state is RUN; done exactly when state is DONE; both decoded from state only.
REQ-018 start while in RUN SHALL be ignored; operands and carry under processing SHALL not change.
REQ-019 sum and c_out SHALL change only on the edge entering DONE and otherwise hold their last value.
REQ-020 Result SHALL equal (a + b + c_in) mod 2^WIDTH, with c_out the carry out of bit WIDTH-1.
REQ-021 Bit counter SHALL be ceil(log2(WIDTH))+1 bits wide, SHALL not wrap during RUN, and SHALL be reloaded to 0 on every start acceptance.

Reset
REQ-022 rst high SHALL immediately, without a clock edge, force state IDLE, busy 0, done 0, sum 0, c_out 0, counter 0, carry flop 0, shift registers 0.
REQ-023 rst asserted mid-RUN SHALL abandon the operation; no done pulse SHALL follow; start SHALL be ignored while rst is high.
REQ-024 The first edge after rst deasserts SHALL follow IDLE rules.

Configuration
REQ-025 Macro SERIAL_ADDER_SUB_EN: when defined, add input port sub (1 bit), sampled with operands; sub=1 loads ~b and forces carry flop <= 1, ignoring c_in, so result = a - b mod 2^WIDTH and c_out = 1 means no borrow.
REQ-026 Without SERIAL_ADDER_SUB_EN, port sub SHALL not exist and the block SHALL only add.

Verification (WIDTH=8)
REQ-027 Reset, then a=0x3C, b=0x15, c_in=0, start pulse at edge E -> busy high edges E+1..E+8, done high one cycle after edge E+8, sum=0x51, c_out=0.
REQ-028 a=0xFF, b=0x01, c_in=0 -> sum=0x00, c_out=1; a=0xFF, b=0xFF, c_in=1 -> sum=0xFF, c_out=1.
REQ-029 Start at E (a=0x01, b=0x01); start again at E+3 with a=0xAA, b=0x55 -> second start ignored, sum=0x02 at done; no extra done pulse.
REQ-030 Start at E, rst pulsed at E+4.5 cycles -> all outputs 0 immediately, no done pulse afterwards; new start then completes normally.
REQ-031 Start held high through DONE -> new operation begins on the edge leaving DONE, done pulses 9 cycles apart, each sum correct, prior sum held until overwritten.
REQ-032 With SERIAL_ADDER_SUB_EN, sub=1, a=0x05, b=0x07 -> sum=0xFE, c_out=0; a=0x07, b=0x05 -> sum=0x02, c_out=1.
